// File: rtl/cycle_tracker.sv
// -----------------------------------------------------------------------------
// cycle_tracker
//
// Receive-side companion to the 3-phase cycler. Samples the 2-bit phase code
// (0 -> 1 -> 2 -> 0) on every rising edge of Clk and does the following:
//   - acquires lock on the sequence (HUNT -> ACQ -> LOCKED)
//   - flywheels through bad samples while locked
//   - reports errors (pulse plus saturating count)
//   - emits a once-per-revolution wrap pulse
//
// Optional feature (compile-time macro):
//   CYCLE_TRACKER_WRAP_CNT_EN
//     defined   : Wrap_Count counts Wrap_Pulse modulo 2^CNT_W
//     undefined : no wrap counter is built and Wrap_Count is tied to 0
//
// Parameters:
//   LOCK_COUNT    consecutive good transitions needed to declare lock (1..15)
//   UNLOCK_COUNT  consecutive bad samples while locked that drop lock (1..15)
//   CNT_W         width of Err_Count and Wrap_Count
//
// Ports:
//   Clk         in   rising-edge clock
//   Reset       in   asynchronous, active-high reset
//   Cycle_In    in   [1:0] phase code from the cycler (3 is illegal)
//   Locked      out  high while in LOCKED
//   Expected    out  [1:0] code expected on the next sample (0 in HUNT)
//   Err_Pulse   out  one-cycle pulse per bad sample while LOCKED
//   Err_Count   out  [CNT_W-1:0] saturating count of bad samples while LOCKED
//   Wrap_Pulse  out  one-cycle pulse per good 2->0 transition while LOCKED
//   Wrap_Count  out  [CNT_W-1:0] wrap pulse counter (see macro above)
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module cycle_tracker #(
  parameter int LOCK_COUNT   = 3,
  parameter int UNLOCK_COUNT = 2,
  parameter int CNT_W        = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [1:0]       Cycle_In,
  output logic             Locked,
  output logic [1:0]       Expected,
  output logic             Err_Pulse,
  output logic [CNT_W-1:0] Err_Count,
  output logic             Wrap_Pulse,
  output logic [CNT_W-1:0] Wrap_Count
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0]       LOCK_CNT4   = 4'(LOCK_COUNT);
  localparam logic [3:0]       UNLOCK_CNT4 = 4'(UNLOCK_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  // Successor of a phase code in the 0 -> 1 -> 2 -> 0 sequence.
  function automatic logic [1:0] nxt(input logic [1:0] p);
    case (p)
      2'd0:    nxt = 2'd1;
      2'd1:    nxt = 2'd2;
      default: nxt = 2'd0;
    endcase
  endfunction

  state_t           state_reg, state_next;
  logic [1:0]       prev_reg, prev_next;
  logic [3:0]       good_cnt_reg, good_cnt_next;
  logic [3:0]       bad_cnt_reg, bad_cnt_next;
  logic             locked_reg, locked_next;
  logic [1:0]       expected_reg, expected_next;
  logic             err_pulse_reg, err_pulse_next;
  logic [CNT_W-1:0] err_count_reg, err_count_next;
  logic             wrap_pulse_reg, wrap_pulse_next;

  logic             is_good;
  logic [3:0]       good_inc;
  logic [3:0]       bad_inc;

  // nxt() never returns 3, so an illegal code can never be classed as good.
  assign is_good  = (Cycle_In == nxt(prev_reg));
  assign good_inc = good_cnt_reg + 4'd1;
  assign bad_inc  = bad_cnt_reg + 4'd1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg      <= HUNT;
      prev_reg       <= 2'd0;
      good_cnt_reg   <= 4'd0;
      bad_cnt_reg    <= 4'd0;
      locked_reg     <= 1'b0;
      expected_reg   <= 2'd0;
      err_pulse_reg  <= 1'b0;
      err_count_reg  <= '0;
      wrap_pulse_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      prev_reg       <= prev_next;
      good_cnt_reg   <= good_cnt_next;
      bad_cnt_reg    <= bad_cnt_next;
      locked_reg     <= locked_next;
      expected_reg   <= expected_next;
      err_pulse_reg  <= err_pulse_next;
      err_count_reg  <= err_count_next;
      wrap_pulse_reg <= wrap_pulse_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    prev_next       = prev_reg;
    good_cnt_next   = good_cnt_reg;
    bad_cnt_next    = bad_cnt_reg;
    err_pulse_next  = 1'b0;
    err_count_next  = err_count_reg;
    wrap_pulse_next = 1'b0;

    case (state_reg)
      HUNT: begin
        if (Cycle_In != 2'd3) begin
          prev_next     = Cycle_In;
          good_cnt_next = 4'd0;
          state_next    = ACQ;
        end
      end

      ACQ: begin
        if (is_good) begin
          prev_next     = Cycle_In;
          good_cnt_next = good_inc;
          if (good_inc == LOCK_CNT4) begin
            state_next   = LOCKED;
            bad_cnt_next = 4'd0;
          end
        end else if (Cycle_In != 2'd3) begin
          // Restart acquisition from the new code.
          prev_next     = Cycle_In;
          good_cnt_next = 4'd0;
        end else begin
          state_next = HUNT;
        end
      end

      LOCKED: begin
        if (is_good) begin
          prev_next    = Cycle_In;
          bad_cnt_next = 4'd0;
          if (prev_reg == 2'd2) begin
            wrap_pulse_next = 1'b1;
          end
        end else begin
          // Flywheel: discard the sample and advance as if it had been good.
          prev_next      = nxt(prev_reg);
          err_pulse_next = 1'b1;
          if (err_count_reg != CNT_MAX) begin
            err_count_next = err_count_reg + 1'b1;
          end
          bad_cnt_next = bad_inc;
          if (bad_inc == UNLOCK_CNT4) begin
            state_next = HUNT;
          end
        end
      end

      default: begin
        state_next = HUNT;
      end
    endcase

    // Outputs are computed from the next state so that they are registered
    // alongside it.
    locked_next   = (state_next == LOCKED);
    expected_next = (state_next == HUNT) ? 2'd0 : nxt(prev_next);
  end

`ifdef CYCLE_TRACKER_WRAP_CNT_EN
  logic [CNT_W-1:0] wrap_count_reg, wrap_count_next;

  always_comb begin
    wrap_count_next = wrap_count_reg;
    if (wrap_pulse_next) begin
      wrap_count_next = wrap_count_reg + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wrap_count_reg <= '0;
    end else begin
      wrap_count_reg <= wrap_count_next;
    end
  end

  assign Wrap_Count = wrap_count_reg;
`else
  assign Wrap_Count = '0;
`endif

  assign Locked     = locked_reg;
  assign Expected   = expected_reg;
  assign Err_Pulse  = err_pulse_reg;
  assign Err_Count  = err_count_reg;
  assign Wrap_Pulse = wrap_pulse_reg;

endmodule

// File: tb/tb_cycle_tracker.sv
// -----------------------------------------------------------------------------
// tb_cycle_tracker
//
// Self-checking bench for cycle_tracker. It runs in phases:
//   - a table of directed vectors from reset
//   - hand-written multi-cycle corner cases (illegal-code hunt, async reset
//     mid-run, error saturation, 257 revolutions for the wrap counter)
//   - randomized stimulus
// The randomized phase is checked against a rule-level behavioural model.
// -----------------------------------------------------------------------------
module tb_cycle_tracker;

  localparam int LOCK_COUNT   = 3;
  localparam int UNLOCK_COUNT = 2;
  localparam int CNT_W        = 8;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic [1:0]       cycle_in;
  logic             locked;
  logic [1:0]       expected;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic             wrap_pulse;
  logic [CNT_W-1:0] wrap_count;

  cycle_tracker #(
    .LOCK_COUNT  (LOCK_COUNT),
    .UNLOCK_COUNT(UNLOCK_COUNT),
    .CNT_W       (CNT_W)
  ) dut (
    .Clk       (clk),
    .Reset     (reset),
    .Cycle_In  (cycle_in),
    .Locked    (locked),
    .Expected  (expected),
    .Err_Pulse (err_pulse),
    .Err_Count (err_count),
    .Wrap_Pulse(wrap_pulse),
    .Wrap_Count(wrap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // m_mode: 0 = hunting, 1 = acquiring, 2 = locked
  int m_mode, m_prev, m_run, m_miss, m_errc, m_wrapc;
  bit m_err, m_wrap;

  function automatic int nx(input int p);
    return (p + 1) % 3;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_run = 0; m_miss = 0;
    m_errc = 0; m_wrapc = 0; m_err = 0; m_wrap = 0;
  endtask

  task automatic model_step(input int s);
    m_err  = 0;
    m_wrap = 0;
    if (m_mode == 0) begin
      if (s != 3) begin
        m_prev = s; m_run = 0; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (s == nx(m_prev)) begin
        m_prev = s;
        m_run++;
        if (m_run == LOCK_COUNT) begin
          m_mode = 2; m_miss = 0;
        end
      end else if (s != 3) begin
        m_prev = s; m_run = 0;
      end else begin
        m_mode = 0;
      end
    end else begin
      if (s == nx(m_prev)) begin
        m_wrap = (m_prev == 2);
        m_prev = s;
        m_miss = 0;
`ifdef CYCLE_TRACKER_WRAP_CNT_EN
        if (m_wrap) m_wrapc = (m_wrapc + 1) % (CNT_MAX + 1);
`endif
      end else begin
        m_prev = nx(m_prev);
        m_err  = 1;
        if (m_errc < CNT_MAX) m_errc++;
        m_miss++;
        if (m_miss == UNLOCK_COUNT) m_mode = 0;
      end
    end
  endtask

  function automatic logic [63:0] model_vec();
    logic [1:0] e;
    e = (m_mode == 0) ? 2'd0 : 2'(nx(m_prev));
    return {38'd0, (m_mode == 2), e, m_err, 8'(m_errc), m_wrap, 8'(m_wrapc)};
  endfunction

  function automatic logic [63:0] dut_vec();
    return {38'd0, locked, expected, err_pulse, err_count, wrap_pulse, wrap_count};
  endfunction

  // Drive one code, let one rising edge sample it, compare on the falling edge.
  task automatic step(input logic [1:0] c, input string name);
    cycle_in = c;
    @(posedge clk);
    model_step(int'(c));
    @(negedge clk);
    check(name, dut_vec(), model_vec());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0] cin;
    logic       lk;
    logic [1:0] ex;
    logic       er;
    logic       wr;
    int         ec;
  } vec_t;

  vec_t tbl[21];

  initial begin
    logic [1:0] c;
    int r;

    tbl[0]  = '{2'd0, 1'b0, 2'd1, 1'b0, 1'b0, 0};
    tbl[1]  = '{2'd1, 1'b0, 2'd2, 1'b0, 1'b0, 0};
    tbl[2]  = '{2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 0};
    tbl[3]  = '{2'd0, 1'b1, 2'd1, 1'b0, 1'b0, 0};  // lock after 4th edge
    tbl[4]  = '{2'd1, 1'b1, 2'd2, 1'b0, 1'b0, 0};
    tbl[5]  = '{2'd2, 1'b1, 2'd0, 1'b0, 1'b0, 0};
    tbl[6]  = '{2'd0, 1'b1, 2'd1, 1'b0, 1'b1, 0};  // wrap
    tbl[7]  = '{2'd3, 1'b1, 2'd2, 1'b1, 1'b0, 1};  // single illegal code
    tbl[8]  = '{2'd2, 1'b1, 2'd0, 1'b0, 1'b0, 1};
    tbl[9]  = '{2'd0, 1'b1, 2'd1, 1'b0, 1'b1, 1};
    tbl[10] = '{2'd1, 1'b1, 2'd2, 1'b0, 1'b0, 1};
    tbl[11] = '{2'd1, 1'b1, 2'd0, 1'b1, 1'b0, 2};  // stall: 1st bad
    tbl[12] = '{2'd1, 1'b0, 2'd0, 1'b1, 1'b0, 3};  // stall: 2nd bad drops lock
    tbl[13] = '{2'd1, 1'b0, 2'd2, 1'b0, 1'b0, 3};  // HUNT -> ACQ from 1
    tbl[14] = '{2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 3};
    tbl[15] = '{2'd0, 1'b0, 2'd1, 1'b0, 1'b0, 3};
    tbl[16] = '{2'd1, 1'b1, 2'd2, 1'b0, 1'b0, 3};  // re-locked
    tbl[17] = '{2'd3, 1'b1, 2'd0, 1'b1, 1'b0, 4};
    tbl[18] = '{2'd3, 1'b0, 2'd0, 1'b1, 1'b0, 5};
    tbl[19] = '{2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 5};  // HUNT ignores 3
    tbl[20] = '{2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 5};  // ACQ from 2

    reset    = 1'b1;
    cycle_in = 2'd0;
    model_reset();
    #1;
    check("reset_state", dut_vec(), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      cycle_in = tbl[i].cin;
      @(posedge clk);
      model_step(int'(tbl[i].cin));
      @(negedge clk);
      check($sformatf("table[%0d]", i),
            {58'd0, locked, expected, err_pulse, wrap_pulse},
            {58'd0, tbl[i].lk, tbl[i].ex, tbl[i].er, tbl[i].wr});
      check($sformatf("table_errcnt[%0d]", i), 64'(err_count), 64'(tbl[i].ec));
    end

    // Illegal code held from reset: stays in HUNT, then locks 4 edges later.
    do_reset();
    for (int i = 0; i < 5; i++) step(2'd3, "hunt_on_3");
    check("hunt_locked", 64'(locked), 64'd0);
    step(2'd1, "acq_1");
    step(2'd2, "acq_2");
    step(2'd0, "acq_0");
    check("not_yet_locked", 64'(locked), 64'd0);
    step(2'd1, "lock_edge4");
    check("locked_after_4", 64'(locked), 64'd1);

    // Async reset mid-operation: outputs clear without a clock edge.
    step(2'd3, "pre_reset_err");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_reset", dut_vec(), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step(2'(i % 3), "post_reset_seq");

    // 300 isolated errors while locked: Err_Count saturates, lock holds.
    for (int i = 0; i < 300; i++) begin
      step(2'd3, "sat_bad");
      step(2'(nx(m_prev)), "sat_good");
    end
    check("err_saturated", 64'(err_count), 64'(CNT_MAX));
    check("sat_still_locked", 64'(locked), 64'd1);

    // 257 revolutions while locked.
    do_reset();
    for (int i = 0; i < 4; i++) step(2'(i % 3), "rev_lock");
    for (int i = 0; i < 257 * 3; i++) step(2'((i + 1) % 3), "rev_run");
`ifdef CYCLE_TRACKER_WRAP_CNT_EN
    check("wrap_count_257", 64'(wrap_count), 64'd1);
`else
    check("wrap_count_257", 64'(wrap_count), 64'd0);
`endif

    // Randomized stimulus: mostly in-sequence codes with some illegal,
    // stalled or random codes mixed in.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 78)      c = 2'(nx(m_prev));
      else if (r < 86) c = 2'd3;
      else if (r < 93) c = 2'(m_prev);
      else             c = 2'($urandom_range(0, 3));
      step(c, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cycle_tracker.md
# cycle_tracker

Receive-side companion to the 3-phase cycler: samples the 2-bit phase code (0→1→2→0) every clock, acquires lock on the sequence, and flags out-of-sequence or illegal codes. It sits downstream of the cycler in Project D and gives consumers a qualified phase, a lock indication, error reporting and a once-per-revolution wrap pulse.

## Interface
- LOCK_COUNT, 3: consecutive good transitions required to declare lock (1..15)
- UNLOCK_COUNT, 2: consecutive bad samples while locked that drop lock (1..15)
- CNT_W, 8: width of Err_Count and Wrap_Count
- Clk  in  1  clock, rising-edge
- Reset  in  1  asynchronous, active-high
- Cycle_In  in  2  phase code from cycler; legal codes 0,1,2; 3 is illegal
- Locked  out  1  high while in LOCKED
- Expected  out  2  phase code expected on the next sample (flywheel value)
- Err_Pulse  out  1  one-cycle pulse per bad sample while LOCKED
- Err_Count  out  CNT_W  saturating count of bad samples while LOCKED
- Wrap_Pulse  out  1  one-cycle pulse per good 2→0 transition while LOCKED
- Wrap_Count  out  CNT_W  modulo-2^CNT_W count of Wrap_Pulse (see Configuration)

## Operation
- nxt(p): 0→1, 1→2, 2→0. A sample s is "good" when s == nxt(prev); code 3 is never good.
- Internal regs: state, prev[1:0], good_cnt[3:0], bad_cnt[3:0].
- HUNT (reset state): if s≠3 → prev<=s, good_cnt<=0, go ACQ; if s==3 stay.
- ACQ: good → prev<=s, good_cnt++; when incremented value == LOCK_COUNT → go LOCKED, bad_cnt<=0. Bad with s≠3 → prev<=s, good_cnt<=0, stay ACQ. s==3 → go HUNT. No errors counted in HUNT/ACQ.
- LOCKED: good → prev<=s, bad_cnt<=0; if prev==2 (s==0) assert Wrap_Pulse. Bad (incl. 3) → prev<=nxt(prev) (flywheel, sample discarded), Err_Pulse=1, Err_Count++ saturating at 2^CNT_W−1, bad_cnt++; when incremented value == UNLOCK_COUNT → go HUNT.
- Expected = nxt(prev) in ACQ/LOCKED; 0 in HUNT.
- Err_Count and Wrap_Count persist across lock loss; cleared only by Reset.

## Timing
- All outputs registered; reset values: Locked=0, Expected=0, Err_Pulse=0, Err_Count=0, Wrap_Pulse=0, Wrap_Count=0, state=HUNT.
- Reset asserted mid-operation: all outputs return to reset values immediately (async); first sample taken on first rising edge after deassertion.
- Clean sequence from reset: edge 1 samples first code (→ACQ); Locked rises after edge 1+LOCK_COUNT (edge 4 with default).
- Err_Pulse/Wrap_Pulse: high for exactly the cycle following the edge that sampled the event; consecutive events give back-to-back pulses.
- Err_Count updates on the same edge that sets Err_Pulse; Locked falls on the edge sampling the UNLOCK_COUNT-th consecutive bad sample, and that sample still produces Err_Pulse.
- A single bad sample followed by a good sample (relative to flywheel) keeps lock; bad_cnt resets.
- Cycler stalled (same code repeated) counts as bad every cycle.

## Configuration
- CYCLE_TRACKER_WRAP_CNT_EN defined: Wrap_Count increments on each Wrap_Pulse, wrapping modulo 2^CNT_W.
- Not defined: counter logic omitted, Wrap_Count tied to 0; Wrap_Pulse unaffected.

## Test plan
- Reset, drive 0,1,2,0,1,2… → Locked=1 after 4th edge, Expected tracks, Wrap_Pulse one cycle after each sampled 2→0, Err_Count stays 0.
- Locked, inject single 3 in place of 1 → Err_Pulse one cycle, Err_Count=1, Locked stays 1, Expected continues 2 next.
- Locked, hold Cycle_In=1 for 3 cycles → Err_Count=2, Locked drops on 2nd bad edge, HUNT then ACQ re-acquires from 1.
- Drive 3 continuously from reset → stays HUNT, Locked=0, Err_Count=0; then legal sequence → locks 4 edges after first legal code.
- Force 300 bad-while-locked events with UNLOCK_COUNT=15 (re-lock between bursts) → Err_Count saturates at 255.
- With CYCLE_TRACKER_WRAP_CNT_EN, run 257 revolutions locked → Wrap_Count=1 (wrapped); without macro → Wrap_Count=0.
